// File: rtl/chip8_timer_bank_pkg.sv
// Purpose: shared defaults and width helper for the CHIP-8 timer bank.
// Latency: none, compile-time constants only.
// Backpressure: none, compile-time constants only.
package chip8_timer_bank_pkg;

`include "chip8.vh"

  // Defaults taken from the interpreter-wide header so the bank and the core agree.
  localparam int DEF_TICK_HZ   = `CHIP8_TICK_HZ;
  localparam int DEF_SOUND_IDX = `CHIP8_TMR_ST;

  // Bit width able to index 0..n-1, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/chip8.vh
// CHIP-8 timer-bank shared constants: interpreter tick rate and channel indices.
// Latency: none, definitions only.
// Backpressure: none, definitions only.
`ifndef CHIP8_VH
`define CHIP8_VH

`define CHIP8_TICK_HZ 60
`define CHIP8_TMR_DT  0
`define CHIP8_TMR_ST  1

`endif

// File: rtl/chip8_tick_gen.sv
// Purpose: free-running divide-by-DIV counter emitting a one-cycle pulse on the last count.
// Latency: pulse is combinational from the counter; first pulse DIV cycles after rst drops.
// Backpressure: none; en pauses the count, rst clears it.
//
// Ports:
//   clk   in  system clock
//   rst   in  synchronous active-high clear of the count
//   en    in  count enable
//   pulse out high while en=1 and the count sits at DIV-1
module chip8_tick_gen
  import chip8_timer_bank_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic pulse
);

  localparam int              CW   = clog2_min1(DIV);
  localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_last ? '0 : r_cnt + CW'(1);
    end
  end

  assign pulse = en & w_last;

endmodule

// File: rtl/chip8_timer_bank.sv
// Purpose: N down-counting CHIP-8 timers (DT, ST, extras) sharing one TICK_HZ prescaler.
// Latency: timer/active/expired update at the write or tick edge; rd_data 1 cycle after rd_sel.
// Backpressure: none; writes and reads are accepted every cycle.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   wr_en/wr_sel/wr_data write strobe, channel, load value (out-of-range channel ignored)
//   rd_sel, rd_data     read channel and registered read data (out-of-range reads 0)
//   tick_o              one-cycle pulse per prescaler tick
//   active              bit i = timer i nonzero
//   expired             one-cycle pulse when timer i ticks 1 -> 0
//   tone                square wave gated by the sound channel
//
// Build option: define CHIP8_TIMER_TONE_EN to build the tone generator; otherwise tone = 0.
module chip8_timer_bank
  import chip8_timer_bank_pkg::*;
#(
  parameter  int CLK_HZ     = 12000000,
  parameter  int TICK_HZ    = DEF_TICK_HZ,
  parameter  int N_TIMERS   = 2,
  parameter  int DATA_WIDTH = 8,
  parameter  int SOUND_IDX  = DEF_SOUND_IDX,
  parameter  int TONE_HZ    = 440,
  localparam int SEL_W      = clog2_min1(N_TIMERS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [SEL_W-1:0]      wr_sel,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [SEL_W-1:0]      rd_sel,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  tick_o,
  output logic [N_TIMERS-1:0]   active,
  output logic [N_TIMERS-1:0]   expired,
  output logic                  tone
);

  localparam int DIV = CLK_HZ / TICK_HZ;

  // Reject configurations that would give a degenerate prescaler or a missing sound channel.
  if ((DIV < 2) || (N_TIMERS < 1) || (SOUND_IDX < 0) || (SOUND_IDX >= N_TIMERS) ||
      (TONE_HZ < 1) || (CLK_HZ / (2 * TONE_HZ) < 1)) begin : g_cfg_err
    $error("chip8_timer_bank: invalid parameter set");
  end

  // ---------------------------------------------------------------------------
  // Shared prescaler
  // ---------------------------------------------------------------------------
  logic w_tick;

  chip8_tick_gen #(
    .DIV (DIV)
  ) u_presc (
    .clk   (clk),
    .rst   (rst),
    .en    (1'b1),
    .pulse (w_tick)
  );

  assign tick_o = w_tick;

  // ---------------------------------------------------------------------------
  // Timer array
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] r_timer     [N_TIMERS];
  logic [DATA_WIDTH-1:0] w_timer_nxt [N_TIMERS];
  logic [N_TIMERS-1:0]   w_act_nxt;
  logic [N_TIMERS-1:0]   w_exp_nxt;
  logic [N_TIMERS-1:0]   r_active;
  logic [N_TIMERS-1:0]   r_expired;
  logic [DATA_WIDTH-1:0] w_rd_nxt;
  logic [DATA_WIDTH-1:0] r_rd_data;

  // A write to a channel overrides that channel's tick decrement, so a reload on a
  // tick cycle lands exactly and can never be reported as an expiry. active is
  // derived from the next value so it flips on the same edge as the timer itself.
  // The read mux looks at the current registers, giving pre-write data on a
  // same-cycle read/write; no match (out-of-range select) leaves the default 0.
  always_comb begin
    w_rd_nxt  = '0;
    w_act_nxt = '0;
    w_exp_nxt = '0;
    for (int i = 0; i < N_TIMERS; i++) begin
      w_timer_nxt[i] = r_timer[i];
      if (wr_en && (wr_sel == SEL_W'(i))) begin
        w_timer_nxt[i] = wr_data;
      end else if (w_tick && (r_timer[i] != '0)) begin
        w_timer_nxt[i] = r_timer[i] - DATA_WIDTH'(1);
        w_exp_nxt[i]   = (r_timer[i] == DATA_WIDTH'(1));
      end
      w_act_nxt[i] = (w_timer_nxt[i] != '0);
      if (rd_sel == SEL_W'(i)) begin
        w_rd_nxt = r_timer[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_TIMERS; i++) begin
        r_timer[i] <= '0;
      end
      r_active  <= '0;
      r_expired <= '0;
      r_rd_data <= '0;
    end else begin
      for (int i = 0; i < N_TIMERS; i++) begin
        r_timer[i] <= w_timer_nxt[i];
      end
      r_active  <= w_act_nxt;
      r_expired <= w_exp_nxt;
      r_rd_data <= w_rd_nxt;
    end
  end

  assign active  = r_active;
  assign expired = r_expired;
  assign rd_data = r_rd_data;

  // ---------------------------------------------------------------------------
  // Tone output
  // ---------------------------------------------------------------------------
`ifdef CHIP8_TIMER_TONE_EN
  localparam int HP = CLK_HZ / (2 * TONE_HZ);

  logic w_snd_on;
  logic w_tone_rst;
  logic w_tone_pulse;
  logic r_tone;

  // Holding the half-period counter in reset while the sound channel is idle makes
  // every burst begin with the same phase: low for HP cycles, then toggling.
  assign w_snd_on   = r_active[SOUND_IDX];
  assign w_tone_rst = rst | ~w_snd_on;

  chip8_tick_gen #(
    .DIV (HP)
  ) u_tone_gen (
    .clk   (clk),
    .rst   (w_tone_rst),
    .en    (w_snd_on),
    .pulse (w_tone_pulse)
  );

  always_ff @(posedge clk) begin
    if (w_tone_rst) begin
      r_tone <= 1'b0;
    end else if (w_tone_pulse) begin
      r_tone <= ~r_tone;
    end
  end

  assign tone = r_tone;
`else
  assign tone = 1'b0;
`endif

endmodule
